mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Requester-side master for the single-port synchronous word memory (12-bit address, 32-bit data, mem_en/read_write strobes).
- Copies a block of LENGTH words from a source base to a destination base by issuing read then write accesses.
- Sits between the CPU control path and the memory port, replacing testbench-style manual strobing with a start/done handshake.

Parameters:
- ADDR_W, 12, memory word-address width
- DATA_W, 32, memory data width
- LEN_W, 13, width of the length field (0..4096 words)
- READ_LAT, 1, cycles from a read request edge until the memory data output is valid (must be >= 1)

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- src_addr  in  ADDR_W  source base word address, latched on accepted start
- dst_addr  in  ADDR_W  destination base word address, latched on accepted start
- length  in  LEN_W  number of words to copy, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  to memory address
- mem_en  out  1  to memory mem_en
- mem_read_write  out  1  to memory read_write; 1 = write, 0 = read
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, mem_en=0, mem_read_write=0, mem_address=0, mem_wdata=0; the index counter and holding register are cleared.
- All memory-side outputs are registered. mem_en is 0 in every state except RD_REQ and WR.
- States:
  - IDLE: on start=1, latch src/dst/length and clear index i. If length=0, go to DONE; otherwise go to RD_REQ.
  - RD_REQ (1 cycle): mem_en=1, mem_read_write=0, mem_address=src+i. Go to RD_WAIT.
  - RD_WAIT (READ_LAT cycles, counted by a wait counter): mem_en=0. On the last cycle, capture mem_rdata into the holding register. Go to WR.
  - WR (1 cycle): mem_en=1, mem_read_write=1, mem_address=dst+i, mem_wdata=holding register. Increment i; if i+1 == length, go to DONE, else go to RD_REQ.
  - DONE (1 cycle): done=1, busy=0. Go to IDLE.
- Throughput: 2+READ_LAT cycles per word. Total cycles from the start edge to the done pulse = length*(2+READ_LAT)+1.
- Address arithmetic is modulo 2^ADDR_W, so src+i or dst+i past 12'hFFF wraps to 12'h000.
- Copy order is ascending and word-by-word, with no overlap protection. With dst=src+1, a source word is propagated forward; this is defined behaviour.
- start while busy, or in DONE, is ignored. Input changes after the start is accepted have no effect.
- Asserting reset mid-copy aborts immediately. Words already written stay written; no done pulse is produced.

Optional Feature:
- Macro MEM_COPY_CHECKSUM_EN.
- Defined: adds output checksum [DATA_W-1:0]. It is cleared on an accepted start and XOR-accumulates every captured word. It is valid and stable from the done cycle until the next accepted start, and reads 0 for length=0.
- Not defined: the checksum port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_copy_pkg holds:
  - the state enum (IDLE, RD_REQ, RD_WAIT, WR, DONE)
  - ADDR_W/DATA_W defaults
  - MEM_RD=1'b0 and MEM_WR=1'b1 encodings
- No sub-module: a single FSM with its datapath. The bench instantiates the existing memory model as the responder.

Test Plan:
- Preload mem[0x010..0x013] = 11111111, 22222222, 33333333, 44444444; start src=0x010, dst=0x100, length=4 -> mem[0x100..0x103] match the source; done pulses exactly 13 cycles after the start edge (READ_LAT=1); busy high in between.
- length=0 with src=0x020, dst=0x030 -> no mem_en assertion; done pulses 1 cycle after start.
- Wrap: src=0xFFE, dst=0x200, length=3, mem[0xFFE]=A, mem[0xFFF]=B, mem[0x000]=C -> mem[0x200..0x202] = A, B, C.
- start pulsed again mid-copy with different src/dst -> ignored; only the first copy's destination is modified.
- Reset asserted during the third word of a 4-word copy -> all outputs 0 asynchronously; first two destination words written, remaining destination words unchanged; no done pulse.
- MEM_COPY_CHECKSUM_EN defined, copy of F0F0F0F0 and 0F0F0F0F -> checksum = FFFFFFFF at done.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding,
// default bus widths and the memory read/write strobe encoding.
package mem_copy_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 13;

   // Memory read_write strobe values
   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR,
      DONE
   } state_e;

endpackage : mem_copy_pkg

// File: rtl/mem_copy_engine.sv
// Block copy master for a single-port synchronous word memory.
// Copies `length` words from src_addr to dst_addr, one read then one write
// per word, ascending, with address wrap at 2^ADDR_W.
// Optional build macro MEM_COPY_CHECKSUM_EN adds an XOR checksum output of
// every word read during the copy.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
`ifdef MEM_COPY_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_en,
   output logic              mem_read_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                en_q, en_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_q, csum_d;
`endif

   // State, datapath and registered memory-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         rw_q    <= MEM_RD;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef MEM_COPY_CHECKSUM_EN
   // Running XOR of captured words, held from DONE until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`else
   // Checksum state is not built in this configuration
`endif

   // Next-state logic; outputs are decoded from the state being entered
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      hold_d  = hold_q;
`ifdef MEM_COPY_CHECKSUM_EN
      csum_d  = csum_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d = src_addr;
               dst_d = dst_addr;
               len_d = length;
               idx_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
               csum_d = '0;
`endif
               state_d = (length == '0) ? DONE : RD_REQ;
            end
         end
         RD_REQ: begin
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               hold_d = mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
               csum_d = csum_q ^ mem_rdata;
`endif
               state_d = WR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         WR: begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = ((idx_q + LEN_W'(1)) == len_q) ? DONE : RD_REQ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      en_d    = 1'b0;
      rw_d    = MEM_RD;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy_d  = (state_d == RD_REQ) || (state_d == RD_WAIT) || (state_d == WR);
      done_d  = (state_d == DONE);

      if (state_d == RD_REQ) begin
         en_d   = 1'b1;
         addr_d = src_d + ADDR_W'(idx_d);
      end else if (state_d == WR) begin
         en_d    = 1'b1;
         rw_d    = MEM_WR;
         addr_d  = dst_d + ADDR_W'(idx_d);
         wdata_d = hold_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign mem_en         = en_q;
   assign mem_read_write = rw_q;
   assign mem_address    = addr_q;
   assign mem_wdata      = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
   assign checksum       = csum_q;
`endif

endmodule : mem_copy_engine
